// File: rtl/mem_access_unit_pkg.sv
// Shared types and constants for the unified instruction/data memory access unit.
package mem_access_unit_pkg;

  localparam int MEM_WORDS_DEF = 32;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    ST_W,
    RMW_RD,
    RMW_WR,
    FAULT
  } mau_state_t;

  // Illegal size or lane misalignment for the given low address bits.
  function automatic logic size_misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic bad;
    bad = 1'b1;
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = lo[0];
      SZ_W:    bad = |lo;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request ports (fetch and load/store) plus the memory-side bus of the access unit.
interface mem_access_unit_if #(
  parameter int AW = 32
);

  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_valid;
  logic [31:0]   if_rdata;
  logic          if_fault;

  logic          d_req;
  logic          d_we;
  logic [1:0]    d_size;
  logic          d_unsigned;
  logic [AW-1:0] d_addr;
  logic [31:0]   d_wdata;
  logic          d_gnt;
  logic          d_valid;
  logic [31:0]   d_rdata;
  logic          d_fault;

  logic [31:0]   mem_addr;
  logic [31:0]   mem_din;
  logic          mem_wen;
  logic [31:0]   mem_dout;

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_valid, if_rdata, if_fault,
    output d_req, d_we, d_size, d_unsigned, d_addr, d_wdata,
    input  d_gnt, d_valid, d_rdata, d_fault,
    input  mem_addr, mem_din, mem_wen,
    output mem_dout
  );

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_valid, if_rdata, if_fault,
    input  d_req, d_we, d_size, d_unsigned, d_addr, d_wdata,
    output d_gnt, d_valid, d_rdata, d_fault,
    output mem_addr, mem_din, mem_wen,
    input  mem_dout
  );

endinterface

// File: rtl/mem_access_unit_lane.sv
// Byte/half lane extraction with sign/zero extension, and sub-word store merging.
module mau_lane_unit
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [15:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  sel_b;
  logic [15:0] sel_h;

  always_comb begin
    sel_b = '0;
    case (lane)
      2'd0: sel_b = word[7:0];
      2'd1: sel_b = word[15:8];
      2'd2: sel_b = word[23:16];
      2'd3: sel_b = word[31:24];
      default: sel_b = '0;
    endcase
    sel_h = lane[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    load_data = word;
    if (size == SZ_B) begin
      load_data = is_unsigned ? {24'd0, sel_b} : {{24{sel_b[7]}}, sel_b};
    end else if (size == SZ_H) begin
      load_data = is_unsigned ? {16'd0, sel_h} : {{16{sel_h[15]}}, sel_h};
    end
  end

  always_comb begin
    merged = word;
    if (size == SZ_B) begin
      case (lane)
        2'd0: merged[7:0]   = wdata[7:0];
        2'd1: merged[15:8]  = wdata[7:0];
        2'd2: merged[23:16] = wdata[7:0];
        2'd3: merged[31:24] = wdata[7:0];
        default: merged = word;
      endcase
    end else if (size == SZ_H) begin
      if (lane[1]) merged[31:16] = wdata;
      else         merged[15:0]  = wdata;
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Arbitrating front end for the unified memory: fetch/load/store, sub-word RMW, fault detection.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int MEM_WORDS = MEM_WORDS_DEF,
  parameter int AW        = 32
) (
  input logic              clk,
  input logic              rst,
  mem_access_unit_if.slave bus
);

  localparam logic [AW:0] LIMIT = (AW+1)'(4 * MEM_WORDS);

  function automatic logic out_of_range(input logic [AW-1:0] a);
    return {1'b0, a} >= LIMIT;
  endfunction

  mau_state_t    state_q, state_d;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [1:0]    size_q;
  logic          uns_q;
  logic          fetch_q;
  logic [31:0]   buf_q;

  logic          if_valid_q, d_valid_q, if_fault_q, d_fault_q;
  logic [31:0]   if_rdata_q, d_rdata_q;

  logic          idle, d_gnt, if_gnt;
  logic          d_fault_now, if_fault_now;
  logic [31:0]   word_idx;
  logic [31:0]   lane_word, load_data, merged;

  assign idle   = (state_q == IDLE);
  assign d_gnt  = idle & bus.d_req;
  assign if_gnt = idle & bus.if_req & ~bus.d_req;

  assign d_fault_now  = out_of_range(bus.d_addr) | size_misaligned(bus.d_size, bus.d_addr[1:0]);
  assign if_fault_now = out_of_range(bus.if_addr) | size_misaligned(SZ_W, bus.if_addr[1:0]);

  assign word_idx  = 32'(addr_q[AW-1:2]);
  assign lane_word = (state_q == RMW_WR) ? buf_q : bus.mem_dout;

  mau_lane_unit u_lane (
    .word        (lane_word),
    .lane        (addr_q[1:0]),
    .size        (size_q),
    .is_unsigned (uns_q),
    .wdata       (wdata_q[15:0]),
    .load_data   (load_data),
    .merged      (merged)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (d_gnt) begin
          if (d_fault_now)              state_d = FAULT;
          else if (!bus.d_we)           state_d = LOAD;
          else if (bus.d_size == SZ_W)  state_d = ST_W;
          else                          state_d = RMW_RD;
        end else if (if_gnt) begin
          state_d = if_fault_now ? FAULT : FETCH;
        end
      end
      RMW_RD:  state_d = RMW_WR;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_addr = '0;
    bus.mem_din  = '0;
    bus.mem_wen  = 1'b0;
    unique case (state_q)
      FETCH, LOAD, RMW_RD: bus.mem_addr = word_idx;
      ST_W: begin
        bus.mem_addr = word_idx;
        bus.mem_din  = wdata_q;
        bus.mem_wen  = 1'b1;
      end
      RMW_WR: begin
        bus.mem_addr = word_idx;
        bus.mem_din  = merged;
        bus.mem_wen  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      size_q     <= '0;
      uns_q      <= 1'b0;
      fetch_q    <= 1'b0;
      buf_q      <= '0;
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
      if_fault_q <= 1'b0;
      d_fault_q  <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;

      if (d_gnt) begin
        addr_q  <= bus.d_addr;
        wdata_q <= bus.d_wdata;
        size_q  <= bus.d_size;
        uns_q   <= bus.d_unsigned;
        fetch_q <= 1'b0;
      end else if (if_gnt) begin
        addr_q  <= bus.if_addr;
        fetch_q <= 1'b1;
      end

      // Responses are registered so each pulse lands in an IDLE cycle that may grant again.
      case (state_q)
        FETCH: begin
          if_valid_q <= 1'b1;
          if_rdata_q <= bus.mem_dout;
          if_fault_q <= 1'b0;
        end
        LOAD: begin
          d_valid_q <= 1'b1;
          d_rdata_q <= load_data;
          d_fault_q <= 1'b0;
        end
        ST_W, RMW_WR: begin
          d_valid_q <= 1'b1;
          d_rdata_q <= '0;
          d_fault_q <= 1'b0;
        end
        RMW_RD: buf_q <= bus.mem_dout;
        FAULT: begin
          if (fetch_q) begin
            if_valid_q <= 1'b1;
            if_rdata_q <= '0;
            if_fault_q <= 1'b1;
          end else begin
            d_valid_q <= 1'b1;
            d_rdata_q <= '0;
            d_fault_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.if_gnt   = if_gnt;
  assign bus.d_gnt    = d_gnt;
  assign bus.if_valid = if_valid_q;
  assign bus.if_rdata = if_rdata_q;
  assign bus.if_fault = if_fault_q;
  assign bus.d_valid  = d_valid_q;
  assign bus.d_rdata  = d_rdata_q;
  assign bus.d_fault  = d_fault_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed literal cases plus random traffic against a per-cycle timeline model.
module tb_mem_access_unit;

  logic clk;
  logic rst;
  logic chk_en;
  logic rst_edge;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] mem      [32];
  logic [31:0] ref_mem  [32];
  logic [31:0] init_mem [32];

  int          wen_count = 0;
  logic [31:0] last_waddr, last_wdata;

  mem_access_unit_if #(.AW(32)) bus ();

  mem_access_unit #(.MEM_WORDS(32), .AW(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rst_edge <= rst;

  assign bus.mem_dout = mem[bus.mem_addr[4:0]];

  always @(posedge clk) begin
    if (!chk_en) mem <= init_mem;
    else if (bus.mem_wen) mem[bus.mem_addr[4:0]] <= bus.mem_din;
  end

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void chkb(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got no event expected one within bound (cycle %0d)", name, cyc);
  endfunction

  // ---------------- behavioural model ----------------
  typedef struct {
    logic        wen;
    logic [31:0] maddr;
    logic [31:0] mdin;
    logic        ifv;
    logic        dv;
    logic [31:0] rdata;
    logic        fault;
  } rec_t;

  rec_t tl[$];
  rec_t cur;
  logic m_idle, exp_dg, exp_ig;

  function automatic rec_t mk(input logic wen, input logic [31:0] ma, input logic [31:0] md,
                              input logic ifv, input logic dv, input logic [31:0] rd, input logic f);
    rec_t r;
    r.wen = wen; r.maddr = ma; r.mdin = md;
    r.ifv = ifv; r.dv = dv; r.rdata = rd; r.fault = f;
    return r;
  endfunction

  function automatic bit m_dfault(input logic [1:0] size, input logic [31:0] a);
    return (a >= 32'd128) || (size == 2'd3) ||
           (size == 2'd1 && (a % 32'd2) != 0) || (size == 2'd2 && (a % 32'd4) != 0);
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] w, input logic [1:0] size,
                                         input logic uns, input logic [31:0] a);
    logic [31:0] v;
    v = w;
    if (size == 2'd0) begin
      v = (w >> (8 * (a % 32'd4))) & 32'hFF;
      if (!uns && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (size == 2'd1) begin
      v = (w >> (16 * ((a / 32'd2) % 32'd2))) & 32'hFFFF;
      if (!uns && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  function automatic logic [31:0] m_merge(input logic [31:0] w, input logic [1:0] size,
                                          input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] sh, m;
    if (size == 2'd0) begin
      sh = 8 * (a % 32'd4);
      m  = 32'hFF << sh;
    end else begin
      sh = 16 * ((a / 32'd2) % 32'd2);
      m  = 32'hFFFF << sh;
    end
    return (w & ~m) | ((wd << sh) & m);
  endfunction

  always @(negedge clk) begin
    if (!chk_en) begin
      ref_mem = init_mem;
      tl.delete();
    end else begin
      if (rst_edge) tl.delete();
      if (tl.size() != 0) cur = tl.pop_front();
      else cur = mk(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
      if (cur.wen) ref_mem[cur.maddr[4:0]] = cur.mdin;
      if (bus.mem_wen) begin
        wen_count++;
        last_waddr = bus.mem_addr;
        last_wdata = bus.mem_din;
      end

      chkb("mem_wen", bus.mem_wen, cur.wen);
      chk("mem_addr", bus.mem_addr, cur.maddr);
      chk("mem_din", bus.mem_din, cur.mdin);
      chkb("if_valid", bus.if_valid, cur.ifv);
      chkb("d_valid", bus.d_valid, cur.dv);
      if (cur.ifv) begin
        chk("if_rdata", bus.if_rdata, cur.rdata);
        chkb("if_fault", bus.if_fault, cur.fault);
      end
      if (cur.dv) begin
        chk("d_rdata", bus.d_rdata, cur.rdata);
        chkb("d_fault", bus.d_fault, cur.fault);
      end

      m_idle = (tl.size() == 0);
      exp_dg = m_idle && bus.d_req;
      exp_ig = m_idle && bus.if_req && !bus.d_req;
      chkb("d_gnt", bus.d_gnt, exp_dg);
      chkb("if_gnt", bus.if_gnt, exp_ig);

      if (!rst && exp_dg) begin
        if (m_dfault(bus.d_size, bus.d_addr)) begin
          tl.push_back(mk(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0));
          tl.push_back(mk(1'b0, '0, '0, 1'b0, 1'b1, '0, 1'b1));
        end else if (!bus.d_we) begin
          tl.push_back(mk(1'b0, bus.d_addr / 4, '0, 1'b0, 1'b0, '0, 1'b0));
          tl.push_back(mk(1'b0, '0, '0, 1'b0, 1'b1,
                          m_load(ref_mem[bus.d_addr[6:2]], bus.d_size, bus.d_unsigned, bus.d_addr), 1'b0));
        end else if (bus.d_size == 2'd2) begin
          tl.push_back(mk(1'b1, bus.d_addr / 4, bus.d_wdata, 1'b0, 1'b0, '0, 1'b0));
          tl.push_back(mk(1'b0, '0, '0, 1'b0, 1'b1, '0, 1'b0));
        end else begin
          tl.push_back(mk(1'b0, bus.d_addr / 4, '0, 1'b0, 1'b0, '0, 1'b0));
          tl.push_back(mk(1'b1, bus.d_addr / 4,
                          m_merge(ref_mem[bus.d_addr[6:2]], bus.d_size, bus.d_addr, bus.d_wdata),
                          1'b0, 1'b0, '0, 1'b0));
          tl.push_back(mk(1'b0, '0, '0, 1'b0, 1'b1, '0, 1'b0));
        end
      end else if (!rst && exp_ig) begin
        if (bus.if_addr >= 32'd128 || (bus.if_addr % 32'd4) != 0) begin
          tl.push_back(mk(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0));
          tl.push_back(mk(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b1));
        end else begin
          tl.push_back(mk(1'b0, bus.if_addr / 4, '0, 1'b0, 1'b0, '0, 1'b0));
          tl.push_back(mk(1'b0, '0, '0, 1'b1, 1'b0, ref_mem[bus.if_addr[6:2]], 1'b0));
        end
      end
    end
  end

  // ---------------- requester tasks ----------------
  task automatic do_data(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic fault,
                         output int lat, output int gcyc);
    int n;
    rdata = '0; fault = 1'b0; lat = -1; gcyc = -1;
    @(posedge clk); #1;
    bus.d_we = we; bus.d_size = size; bus.d_unsigned = uns;
    bus.d_addr = addr; bus.d_wdata = wdata; bus.d_req = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.d_gnt && n < 400);
    if (!bus.d_gnt) begin
      timeout("d_gnt_wait");
      bus.d_req = 1'b0;
      return;
    end
    gcyc = cyc;
    @(posedge clk); #1;
    bus.d_req = 1'b0;
    bus.d_we = 1'($urandom); bus.d_size = 2'($urandom);
    bus.d_addr = $urandom; bus.d_wdata = $urandom; bus.d_unsigned = 1'($urandom);
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.d_valid && n < 10);
    if (!bus.d_valid) begin
      timeout("d_valid_wait");
      return;
    end
    rdata = bus.d_rdata;
    fault = bus.d_fault;
    lat   = cyc - gcyc;
  endtask

  task automatic do_fetch(input logic [31:0] addr,
                          output logic [31:0] rdata, output logic fault,
                          output int lat, output int gcyc);
    int n;
    rdata = '0; fault = 1'b0; lat = -1; gcyc = -1;
    @(posedge clk); #1;
    bus.if_addr = addr; bus.if_req = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.if_gnt && n < 400);
    if (!bus.if_gnt) begin
      timeout("if_gnt_wait");
      bus.if_req = 1'b0;
      return;
    end
    gcyc = cyc;
    @(posedge clk); #1;
    bus.if_req  = 1'b0;
    bus.if_addr = $urandom;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.if_valid && n < 10);
    if (!bus.if_valid) begin
      timeout("if_valid_wait");
      return;
    end
    rdata = bus.if_rdata;
    fault = bus.if_fault;
    lat   = cyc - gcyc;
  endtask

  // ---------------- directed + random stimulus ----------------
  logic [31:0] r1, r2;
  logic        f1, f2;
  int          l1, l2, g1, g2, wc0;

  initial begin
    for (int i = 0; i < 32; i++) init_mem[i] = $urandom;
    init_mem[1] = 32'h1234_5678;
    chk_en = 1'b0;
    rst = 1'b1;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_size = '0; bus.d_unsigned = 1'b0;
    bus.d_addr = '0; bus.d_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_en = 1'b1;

    @(negedge clk);
    chkb("rst_if_valid", bus.if_valid, 1'b0);
    chkb("rst_d_valid", bus.d_valid, 1'b0);
    chkb("rst_if_fault", bus.if_fault, 1'b0);
    chkb("rst_d_fault", bus.d_fault, 1'b0);
    chk("rst_if_rdata", bus.if_rdata, 32'h0);
    chk("rst_d_rdata", bus.d_rdata, 32'h0);
    chkb("rst_mem_wen", bus.mem_wen, 1'b0);

    // word store then load
    wc0 = wen_count;
    do_data(1'b1, 2'd2, 1'b0, 32'h08, 32'hDEAD_BEEF, r1, f1, l1, g1);
    chk("sw_writes", wen_count - wc0, 32'd1);
    chk("sw_waddr", last_waddr, 32'd2);
    chk("sw_wdata", last_wdata, 32'hDEAD_BEEF);
    chk("sw_lat", l1, 32'd2);
    do_data(1'b0, 2'd2, 1'b0, 32'h08, 32'h0, r1, f1, l1, g1);
    chk("lw_data", r1, 32'hDEAD_BEEF);
    chkb("lw_fault", f1, 1'b0);
    chk("lw_lat", l1, 32'd2);

    // sub-word loads
    do_data(1'b0, 2'd0, 1'b0, 32'h0B, 32'h0, r1, f1, l1, g1);
    chk("lb_signed", r1, 32'hFFFF_FFDE);
    do_data(1'b0, 2'd0, 1'b1, 32'h0B, 32'h0, r1, f1, l1, g1);
    chk("lbu", r1, 32'h0000_00DE);
    do_data(1'b0, 2'd1, 1'b0, 32'h08, 32'h0, r1, f1, l1, g1);
    chk("lh_signed", r1, 32'hFFFF_BEEF);

    // byte store read-modify-write
    wc0 = wen_count;
    do_data(1'b1, 2'd0, 1'b0, 32'h09, 32'hAAAA_AA55, r1, f1, l1, g1);
    chk("sb_writes", wen_count - wc0, 32'd1);
    chk("sb_wdata", last_wdata, 32'hDEAD_55EF);
    chk("sb_lat", l1, 32'd3);

    // faults
    wc0 = wen_count;
    do_data(1'b0, 2'd1, 1'b0, 32'h05, 32'h0, r1, f1, l1, g1);
    chkb("lh_mis_fault", f1, 1'b1);
    chk("lh_mis_rdata", r1, 32'h0);
    chk("lh_mis_lat", l1, 32'd2);
    do_data(1'b1, 2'd3, 1'b0, 32'h00, 32'h1234, r1, f1, l1, g1);
    chkb("size3_fault", f1, 1'b1);
    chk("fault_writes", wen_count - wc0, 32'd0);
    do_fetch(32'h80, r2, f2, l2, g2);
    chkb("fetch_oor_fault", f2, 1'b1);
    chk("fetch_oor_rdata", r2, 32'h0);

    // arbitration: data wins, fetch granted when the load returns to IDLE
    fork
      do_data(1'b0, 2'd2, 1'b0, 32'h08, 32'h0, r1, f1, l1, g1);
      do_fetch(32'h04, r2, f2, l2, g2);
    join
    chk("arb_gap", g2 - g1, 32'd2);
    chk("arb_load", r1, 32'hDEAD_55EF);
    chk("fetch_w1", r2, 32'h1234_5678);
    chkb("fetch_w1_fault", f2, 1'b0);
    chk("fetch_lat", l2, 32'd2);

    // reset while a byte store sits in its read phase
    wc0 = wen_count;
    @(posedge clk); #1;
    bus.d_we = 1'b1; bus.d_size = 2'd0; bus.d_unsigned = 1'b0;
    bus.d_addr = 32'h0A; bus.d_wdata = 32'h77; bus.d_req = 1'b1;
    @(negedge clk);
    chkb("rmw_rst_gnt", bus.d_gnt, 1'b1);
    @(posedge clk); #1;
    bus.d_req = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_d_rdata", bus.d_rdata, 32'h0);
    chk("rst_mid_if_rdata", bus.if_rdata, 32'h0);
    chk("rst_mid_mem_addr", bus.mem_addr, 32'h0);
    chkb("rst_mid_if_valid", bus.if_valid, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chkb("rst_mid_no_dvalid", bus.d_valid, 1'b0);
      @(negedge clk);
    end
    chk("rst_mid_writes", wen_count - wc0, 32'd0);
    chk("rst_mid_word2", mem[2], 32'hDEAD_55EF);

    // random concurrent traffic
    fork
      begin
        logic [31:0] ra, rd;
        logic        rf;
        int          rl, rg;
        for (int k = 0; k < 150; k++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          case ($urandom_range(0, 9))
            0:       ra = $urandom_range(128, 200);
            1:       ra = 32'hFFFF_FFFC;
            default: ra = $urandom_range(0, 127);
          endcase
          do_data(1'($urandom), 2'($urandom), 1'($urandom), ra, $urandom, rd, rf, rl, rg);
        end
      end
      begin
        logic [31:0] fa, fd;
        logic        ff;
        int          fl, fg;
        for (int k = 0; k < 150; k++) begin
          repeat ($urandom_range(0, 4)) @(posedge clk);
          case ($urandom_range(0, 9))
            0:       fa = $urandom_range(0, 127);
            1:       fa = 32'd4 * $urandom_range(32, 40);
            default: fa = 32'd4 * $urandom_range(0, 31);
          endcase
          do_fetch(fa, fd, ff, fl, fg);
        end
      end
    join

    repeat (4) @(negedge clk);
    for (int i = 0; i < 32; i++) chk("mem_final", mem[i], ref_mem[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got no finish expected one before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
